// File: rtl/instr_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to the
// instruction memory from address 0, holding the core in reset until done. INSTR_LOADER_CHECKSUM_EN adds an XOR check byte.
module instr_loader #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  input  logic        restart_i,
  output logic        wr_en_o,
  output logic [29:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
`ifdef INSTR_LOADER_CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic                rdy_q, rdy_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]          ck_q, ck_d;
`endif

  logic        accept;
  logic [15:0] len_w;

  // rdy_q always mirrors "state_q is an accepting state"
  assign accept = byte_valid_i && rdy_q;
  assign len_w  = {byte_i, len_lo_q};

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    ck_d       = ck_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_i;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (len_w == 16'd0 || 32'(len_w) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            last_d     = ADDR_W'(len_w - 16'd1);
            word_cnt_d = '0;
            byte_cnt_d = 2'd0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          ck_d = ck_q ^ byte_i;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = byte_i;
            2'd1: asm_d[15:8]  = byte_i;
            2'd2: asm_d[23:16] = byte_i;
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = word_cnt_q[ADDR_W-1:0];
              wr_data_d  = {byte_i, asm_q};
              word_cnt_d = word_cnt_q + CNT_W'(1);
              if (word_cnt_q == CNT_W'(last_q)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                state_d = S_CHK;
`else
                state_d = S_DONE;
`endif
              end
            end
          endcase
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (byte_i == ck_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (restart_i) begin
          word_cnt_d = '0;
          byte_cnt_d = 2'd0;
          asm_d      = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          ck_d       = 8'd0;
`endif
          state_d    = S_LEN_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // status outputs are registered decodes of the next state
    rdy_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA)
`ifdef INSTR_LOADER_CHECKSUM_EN
                || (state_d == S_CHK)
`endif
                ;
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_lo_q   <= 8'd0;
      last_q     <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      rdy_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      ck_q       <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      rdy_q      <= rdy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      ck_q       <= ck_d;
`endif
    end
  end

  assign byte_ready_o = rdy_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = {{(30-ADDR_W){1'b0}}, wr_addr_q};
  assign wr_data_o    = wr_data_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
